// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC register, ROM address drive and in-order fetch queue
// feeding decode over valid/ready; redirects flush the queue and reload PC.
// Ports: clk, rst_n (sync, active-low), rom_addr/rom_inst (combinational
// ROM), redirect_valid/redirect_pc, id_ready/id_valid/id_inst/id_pc/
// id_pc_next (decode handshake).
// Optional macro IFU_NOP_SQUASH_EN: all-zero ROM words are skipped
// (PC still advances) so they never reach decode.
module inst_fetch_unit #(
    parameter int            AW       = 6,
    parameter int            DW       = 32,
    parameter int            QDEPTH   = 2,
    parameter logic [AW-1:0] RESET_PC = AW'(1)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_inst,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          id_ready,
    output logic          id_valid,
    output logic [DW-1:0] id_inst,
    output logic [AW-1:0] id_pc,
    output logic [AW-1:0] id_pc_next
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [AW-1:0] pc_q, pc_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] inst_q [QDEPTH];
    logic [AW-1:0] ipc_q  [QDEPTH];

    logic pop;
    logic adv;
    logic wr;

    assign rom_addr   = pc_q;
    assign id_valid   = (count_q != '0);
    assign id_inst    = inst_q[rptr_q];
    assign id_pc      = ipc_q[rptr_q];
    assign id_pc_next = id_pc + AW'(1);

    assign pop = id_valid && id_ready;
    // A slot frees up this cycle if the head is being popped.
    assign adv = !redirect_valid && ((count_q < FULL) || pop);

`ifdef IFU_NOP_SQUASH_EN
    // Zero words consume a fetch slot in PC terms but are never stored.
    assign wr = adv && (rom_inst != '0);
`else
    assign wr = adv;
`endif

    always_comb begin
        pc_d    = pc_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (adv) pc_d = pc_q + AW'(1);
            if (wr)  wptr_d = wptr_q + PW'(1);
            if (pop) rptr_d = rptr_q + PW'(1);
            if (wr && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!wr && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                inst_q[i] <= '0;
                ipc_q[i]  <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            if (wr) begin
                inst_q[wptr_q] <= rom_inst;
                ipc_q[wptr_q]  <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: scoreboard bench for inst_fetch_unit.
// ROM model returns 32'hA000_0000 | addr (optionally 0 at address 2).
module tb_inst_fetch_unit;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int QD = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_inst;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          id_ready = 1'b1;
    logic          id_valid;
    logic [DW-1:0] id_inst;
    logic [AW-1:0] id_pc;
    logic [AW-1:0] id_pc_next;
    logic          zero_at2 = 1'b0;

    int total = 0;
    int bad = 0;

    logic [AW-1:0] expq [$];

    always #5 clk = ~clk;

    assign rom_inst = (zero_at2 && rom_addr == 6'd2) ? 32'h0
                    : (32'hA000_0000 | {26'd0, rom_addr});

    inst_fetch_unit #(
        .AW(AW), .DW(DW), .QDEPTH(QD), .RESET_PC(6'h01)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rom_addr(rom_addr),
        .rom_inst(rom_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .id_valid(id_valid),
        .id_inst(id_inst),
        .id_pc(id_pc),
        .id_pc_next(id_pc_next)
    );

    function automatic logic [DW-1:0] exp_inst(input logic [AW-1:0] pc);
        if (zero_at2 && pc == 6'd2) return 32'h0;
        return 32'hA000_0000 | {26'd0, pc};
    endfunction

    // Called at a negedge with id_ready=1; pops one expected entry per
    // valid cycle and counts empty cycles until the scoreboard drains.
    task automatic drain_sb(input string tag, input int exp_gaps);
        int gaps;
        logic [AW-1:0] e;
        logic [AW-1:0] en;
        gaps = 0;
        for (int i = 0; i < 40 && expq.size() > 0; i++) begin
            if (id_valid) begin
                e  = expq.pop_front();
                en = e + 6'd1;
                total++;
                if (id_pc !== e) begin
                    bad++;
                    $display("FAIL %s id_pc got=%h exp=%h", tag, id_pc, e);
                end
                total++;
                if (id_inst !== exp_inst(e)) begin
                    bad++;
                    $display("FAIL %s id_inst got=%h exp=%h",
                             tag, id_inst, exp_inst(e));
                end
                total++;
                if (id_pc_next !== en) begin
                    bad++;
                    $display("FAIL %s id_pc_next got=%h exp=%h",
                             tag, id_pc_next, en);
                end
            end else begin
                gaps++;
            end
            @(negedge clk);
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL %s timeout left=%0d exp=0", tag, expq.size());
            expq.delete();
        end
        total++;
        if (gaps != exp_gaps) begin
            bad++;
            $display("FAIL %s gaps got=%0d exp=%0d", tag, gaps, exp_gaps);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (rom_addr !== 6'h01) begin
            bad++; $display("FAIL rst rom_addr got=%h exp=01", rom_addr);
        end
        total++;
        if (id_valid !== 1'b0) begin
            bad++; $display("FAIL rst id_valid got=%b exp=0", id_valid);
        end
        total++;
        if (id_inst !== 32'h0) begin
            bad++; $display("FAIL rst id_inst got=%h exp=0", id_inst);
        end
        total++;
        if (id_pc !== 6'h00) begin
            bad++; $display("FAIL rst id_pc got=%h exp=00", id_pc);
        end
        total++;
        if (id_pc_next !== 6'h01) begin
            bad++; $display("FAIL rst id_pc_next got=%h exp=01", id_pc_next);
        end
    endtask

    task automatic test_stream();
        rst_n = 1'b1;
        for (int p = 1; p <= 6; p++) expq.push_back(AW'(p));
        drain_sb("stream", 1);
    endtask

    task automatic test_backpressure();
        rst_n = 1'b0;
        id_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (id_valid !== 1'b1 || id_pc !== 6'h01) begin
            bad++;
            $display("FAIL bp_first valid=%b pc=%h exp=1/01", id_valid, id_pc);
        end
        repeat (4) @(negedge clk);
        total++;
        if (rom_addr !== 6'h03) begin
            bad++; $display("FAIL bp rom_addr got=%h exp=03", rom_addr);
        end
        total++;
        if (id_valid !== 1'b1 || id_pc !== 6'h01) begin
            bad++;
            $display("FAIL bp_head valid=%b pc=%h exp=1/01", id_valid, id_pc);
        end
        id_ready = 1'b1;
        for (int p = 1; p <= 4; p++) expq.push_back(AW'(p));
        drain_sb("bp_resume", 0);
    endtask

    task automatic test_redirect_full();
        id_ready = 1'b0;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 6'h0A;
        @(negedge clk);
        total++;
        if (id_valid !== 1'b0) begin
            bad++; $display("FAIL redir id_valid got=%b exp=0", id_valid);
        end
        total++;
        if (rom_addr !== 6'h0A) begin
            bad++; $display("FAIL redir rom_addr got=%h exp=0a", rom_addr);
        end
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        expq.push_back(6'h0A);
        expq.push_back(6'h0B);
        expq.push_back(6'h0C);
        drain_sb("redir", 1);
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 6'h3E;
        @(negedge clk);
        total++;
        if (id_valid !== 1'b0 || rom_addr !== 6'h3E) begin
            bad++;
            $display("FAIL wrap_redir valid=%b addr=%h exp=0/3e",
                     id_valid, rom_addr);
        end
        redirect_valid = 1'b0;
        expq.push_back(6'h3E);
        expq.push_back(6'h3F);
        expq.push_back(6'h00);
        expq.push_back(6'h01);
        drain_sb("wrap", 1);
    endtask

    task automatic test_reset_mid();
        id_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (id_valid !== 1'b1) begin
            bad++; $display("FAIL rmid_pre id_valid got=%b exp=1", id_valid);
        end
        rst_n = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 6'h20;
        @(negedge clk);
        total++;
        if (id_valid !== 1'b0) begin
            bad++; $display("FAIL rmid id_valid got=%b exp=0", id_valid);
        end
        total++;
        if (rom_addr !== 6'h01) begin
            bad++; $display("FAIL rmid rom_addr got=%h exp=01", rom_addr);
        end
        total++;
        if (id_pc !== 6'h00 || id_inst !== 32'h0) begin
            bad++;
            $display("FAIL rmid head pc=%h inst=%h exp=00/0", id_pc, id_inst);
        end
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        expq.push_back(6'h01);
        expq.push_back(6'h02);
        expq.push_back(6'h03);
        drain_sb("rmid", 1);
    endtask

    task automatic test_nop_squash();
        rst_n = 1'b0;
        zero_at2 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef IFU_NOP_SQUASH_EN
        expq.push_back(6'h01);
        expq.push_back(6'h03);
        expq.push_back(6'h04);
        drain_sb("squash", 2);
`else
        expq.push_back(6'h01);
        expq.push_back(6'h02);
        expq.push_back(6'h03);
        drain_sb("zero_word", 1);
`endif
        zero_at2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_wrap();
        test_reset_mid();
        test_nop_squash();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
